// File: rtl/shift_right_seq.sv
// rtl/shift_right_seq.sv - iterative logical/arithmetic right shifter for the lsr/asr ALU path
//
// Applies one binary-weighted shift stage (1, 2, 4, 8, 16) per cycle, so every
// operation takes a fixed 5 cycles regardless of the shift amount.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset (aborts any operation in flight)
//   start  request; accepted only when busy=0 (IDLE or DONE)
//   arith  0 = logical shift (zero fill), 1 = arithmetic shift (sign fill)
//   d      operand to shift
//   sel    shift amount
//   busy   high while the shift stages are running; start is ignored then
//   done   one-cycle pulse; y is valid from this cycle on
//   y      registered result, held between operations
module shift_right_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               arith,
    input  logic [WIDTH-1:0]   d,
    input  logic [SHAMT_W-1:0] sel,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   y
);

    localparam int K_W = 3;
    localparam logic [K_W-1:0] LAST_STAGE = K_W'(SHAMT_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] amount;
    logic               mode;
    logic [K_W-1:0]     k;
    logic [WIDTH-1:0]   stage_out;
    logic [SHAMT_W-1:0] shift_dist;
    logic               accept;

    // A new request is taken in IDLE and also in DONE, which gives
    // back-to-back operation without an idle cycle in between.
    assign accept = start && (state != SHIFT);

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // Stage k shifts by 2^k when amount bit k is set. The sign fill uses the
    // current work MSB, which never changes across stages, so the result
    // equals a single signed shift of the original operand.
    always_comb begin
        shift_dist = {{(SHAMT_W-1){1'b0}}, 1'b1} << k;
        stage_out  = work;
        if (amount[k]) begin
            if (mode) begin
                stage_out = $signed(work) >>> shift_dist;
            end else begin
                stage_out = work >> shift_dist;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (k == LAST_STAGE) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work   <= '0;
            amount <= '0;
            mode   <= 1'b0;
            k      <= '0;
            y      <= '0;
        end else if (accept) begin
            work   <= d;
            amount <= sel;
            mode   <= arith;
            k      <= '0;
        end else if (state == SHIFT) begin
            work <= stage_out;
            k    <= k + K_W'(1);
            // y only moves on the completion edge so it holds the previous
            // result for the whole duration of the next operation.
            if (k == LAST_STAGE) begin
                y <= stage_out;
            end
        end
    end

endmodule

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
Iterative logical/arithmetic right shifter for the SimpleRISC ALU. It covers the `lsr` and `asr` instructions and is the counterpart of the combinational left shifter. Each cycle it applies one binary-weighted stage (1, 2, 4, 8, 16), so a full 32-bit shift finishes in a fixed 5 cycles. It is controlled by a start/busy/done handshake from the execute-stage controller, which stalls while `busy` is high.

Parameters:
WIDTH, 32, data width; fixed at 32 for SimpleRISC.
SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
arith  input  1  0 = logical (lsr, zero fill); 1 = arithmetic (asr, sign fill)
d  input  32  operand to shift
sel  input  5  shift amount, 0–31
busy  output  1  operation in progress; start is ignored
done  output  1  one-cycle pulse; y is valid from this cycle on
y  output  32  registered result

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, y=0, busy=0, done=0.
  - Internal work register, amount, mode and stage counter are all cleared.
  - Reset asserted mid-operation aborts the shift; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: capture d into the work register, sel into amount, arith into mode.
  - Also set stage counter k=0 and go to SHIFT.
  - busy=1 from the following cycle.
- SHIFT, each edge:
  - If amount[k]=1, work = work >> 2^k, filling with 0 (mode=0) or with the work MSB (mode=1).
  - If amount[k]=0, work is unchanged.
  - Then k=k+1.
  - The edge with k=4 also writes the final value to y and goes to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle; y holds the new result.
  - Next edge goes to IDLE, or directly into SHIFT if start=1 (back-to-back acceptance).
- Latency: start accepted at edge E0 → done high in the cycle after edge E5 (5 cycles). Latency is fixed and independent of sel, including sel=0.
- busy=1 only in SHIFT; done=1 only in DONE.
- start while busy=1 is ignored, not queued. Changes to d/sel/arith during SHIFT have no effect.
- y changes only on the completion edge (or on reset). Between operations it holds the last result.
- Sign fill uses the current work MSB at each stage. This equals the original d[31], so ASR by n equals a signed shift of d.
- Boundaries:
  - sel=31 with arith=1 yields all 0s or all 1s according to d[31].
  - sel=0 yields y=d.
  - There is no carry/overflow output.

Test Plan:
- Reset, then start with arith=0, d=0x80000000, sel=31 → busy high for 5 cycles; done pulses once; y=0x00000001.
- arith=1, d=0x80000000, sel=4 → y=0xF8000000. Same operands with arith=0 → y=0x08000000.
- arith=1, d=0x7FFFFFFF, sel=31 → y=0x00000000. arith=1, d=0xFFFFFFFF, sel=17 → y=0xFFFFFFFF. arith=0, d=0xDEADBEEF, sel=0 → y=0xDEADBEEF after the full 5 cycles.
- Start d=0x0000F000, sel=12, arith=0; pulse start with d=0x1, sel=1 while busy=1 → ignored; y=0x0000000F; exactly one done pulse.
- Back-to-back: assert start in the DONE cycle with d=0x00000100, sel=8 → first y observed at its done; second done exactly 5 cycles later with y=0x00000001; no idle gap.
- Assert rst two cycles into an operation → y=0, busy=0 and done=0 immediately (asynchronous); no done afterwards. A fresh start after reset completes normally.
